// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Two-requester round-robin arbiter that issues one register
//                write every two cycles through a two-state IDLE/WRITE FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int WIDTH = 10,
    parameter int NREG  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [2:0]       addr0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [2:0]       addr1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [NREG-1:0]  chosen,
    output logic             w_en,
    output logic [WIDTH-1:0] w_data,
    output logic             busy,
    output logic             err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    localparam logic [3:0]      c_nreg = 4'(NREG);
    localparam logic [NREG-1:0] c_one  = NREG'(1);

    state_t           r_state;
    logic             r_last;

    logic             w_winner;
    logic [2:0]       w_sel_addr;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_addr_ok;
    logic [NREG-1:0]  w_onehot;

    // On contention the requester that was not served last wins.
    always_comb begin
        w_winner   = (req0 && req1) ? ~r_last : req1;
        w_sel_addr = w_winner ? addr1 : addr0;
        w_sel_data = w_winner ? data1 : data0;
        w_addr_ok  = ({1'b0, w_sel_addr} < c_nreg);
        w_onehot   = c_one << w_sel_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            chosen  <= '0;
            w_en    <= 1'b0;
            w_data  <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_state <= ST_WRITE;
                        r_last  <= w_winner;
                        gnt0    <= ~w_winner;
                        gnt1    <= w_winner;
                        w_data  <= w_sel_data;
                        busy    <= 1'b1;
                        // Out-of-range targets still get granted, but nothing is written.
                        if (w_addr_ok) begin
                            w_en   <= 1'b1;
                            chosen <= w_onehot;
                        end else begin
                            w_en   <= 1'b0;
                            chosen <= '0;
                            err    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    chosen  <= '0;
                    w_en    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Directed self-checking bench for reg_write_arbiter with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int WIDTH = 10;
    localparam int NREG  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0 = 1'b0;
    logic [2:0]       addr0 = '0;
    logic [WIDTH-1:0] data0 = '0;
    logic             req1 = 1'b0;
    logic [2:0]       addr1 = '0;
    logic [WIDTH-1:0] data1 = '0;
    logic             gnt0, gnt1, w_en, busy, err;
    logic [NREG-1:0]  chosen;
    logic [WIDTH-1:0] w_data;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .addr0  (addr0),
        .data0  (data0),
        .req1   (req1),
        .addr1  (addr1),
        .data1  (data1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .chosen (chosen),
        .w_en   (w_en),
        .w_data (w_data),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one granted transaction occupies exactly one cycle,
    // followed by a mandatory idle cycle.
    logic             m_in_write, m_last, m_err, m_g0, m_g1, m_wen;
    logic [NREG-1:0]  m_chosen;
    logic [WIDTH-1:0] m_wdata;
    int               m_who, m_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_write = 0; m_last = 1; m_err = 0;
            m_g0 = 0; m_g1 = 0; m_wen = 0; m_chosen = '0; m_wdata = '0;
        end else if (m_in_write) begin
            m_in_write = 0; m_g0 = 0; m_g1 = 0; m_wen = 0; m_chosen = '0;
        end else if (req0 || req1) begin
            if (req0 && req1) m_who = (m_last == 1'b1) ? 0 : 1;
            else              m_who = req1 ? 1 : 0;
            m_last     = (m_who == 1);
            m_in_write = 1;
            m_g0       = (m_who == 0);
            m_g1       = (m_who == 1);
            m_addr     = (m_who == 1) ? int'(addr1) : int'(addr0);
            m_wdata    = (m_who == 1) ? data1 : data0;
            m_chosen   = '0;
            if (m_addr < NREG) begin
                m_wen = 1;
                m_chosen[m_addr] = 1'b1;
            end else begin
                m_wen = 0;
                m_err = 1;
            end
        end
    end

    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt0",   32'(gnt0),   32'(m_g0));
            check("gnt1",   32'(gnt1),   32'(m_g1));
            check("w_en",   32'(w_en),   32'(m_wen));
            check("chosen", 32'(chosen), 32'(m_chosen));
            check("w_data", 32'(w_data), 32'(m_wdata));
            check("busy",   32'(busy),   32'(m_in_write));
            check("err",    32'(err),    32'(m_err));
            check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            check("chosen_onehot0", 32'($countones(chosen) <= 1), 32'd1);
            check("wen_has_target", 32'(w_en && (chosen == '0)), 32'd0);
            check("no_back_to_back", 32'(busy && prev_busy), 32'd0);
        end
        prev_busy <= busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_gnt0",   32'(gnt0),   32'd0);
        check("rst_gnt1",   32'(gnt1),   32'd0);
        check("rst_w_en",   32'(w_en),   32'd0);
        check("rst_chosen", 32'(chosen), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_err",    32'(err),    32'd0);
        @(posedge clk); #1 rst = 1'b0;
        step();

        // Single request
        req0 = 1; addr0 = 3'd2; data0 = 10'h155;
        step();
        req0 = 0;
        check("single_gnt0",   32'(gnt0),   32'd1);
        check("single_gnt1",   32'(gnt1),   32'd0);
        check("single_w_en",   32'(w_en),   32'd1);
        check("single_chosen", 32'(chosen), 32'b000100);
        check("single_w_data", 32'(w_data), 32'h155);
        step();
        check("single_idle_busy", 32'(busy),   32'd0);
        check("single_hold_data", 32'(w_data), 32'h155);

        // Contention after reset: 0,1,0,1 every second cycle
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req0 = 1; addr0 = 3'd0; data0 = 10'h011;
        req1 = 1; addr1 = 3'd5; data1 = 10'h2AA;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("cont_gnt0", 32'(gnt0), 32'((i % 4) == 1));
            check("cont_gnt1", 32'(gnt1), 32'((i % 4) == 3));
        end
        req0 = 0; req1 = 0;
        step();

        // Out-of-range address
        req1 = 1; addr1 = 3'd7; data1 = 10'h0AB;
        step();
        req1 = 0;
        check("oor_gnt1",   32'(gnt1),   32'd1);
        check("oor_w_en",   32'(w_en),   32'd0);
        check("oor_chosen", 32'(chosen), 32'd0);
        check("oor_err",    32'(err),    32'd1);
        for (int i = 0; i < 10; i++) step();
        check("oor_err_sticky", 32'(err), 32'd1);

        // Input change during WRITE
        req0 = 1; addr0 = 3'd1; data0 = 10'h3FF;
        step();
        req0 = 0; data0 = 10'h000;
        @(negedge clk);
        check("hold_w_data",  32'(w_data), 32'h3FF);
        check("hold_chosen",  32'(chosen), 32'b000010);
        step();
        check("hold_w_data2", 32'(w_data), 32'h3FF);
        step();

        // Reset in the middle of a write
        req0 = 1; addr0 = 3'd3; data0 = 10'h123;
        step();
        req0 = 0;
        check("pre_abort_w_en", 32'(w_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_w_en",   32'(w_en),   32'd0);
        check("abort_gnt0",   32'(gnt0),   32'd0);
        check("abort_chosen", 32'(chosen), 32'd0);
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_err",    32'(err),    32'd0);
        req0 = 1; addr0 = 3'd2; data0 = 10'h0F0;
        req1 = 1; addr1 = 3'd4; data1 = 10'h00F;
        @(posedge clk); #1 rst = 1'b0;
        step();
        req0 = 0; req1 = 0;
        check("post_rst_gnt0",   32'(gnt0),   32'd1);
        check("post_rst_gnt1",   32'(gnt1),   32'd0);
        check("post_rst_chosen", 32'(chosen), 32'b000100);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 10: data width of each register write.
REQ-002 Parameter NREG, default 6: number of registers; valid addresses are 0..NREG-1, and the maximum supported NREG is 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  write request from requester 0; held high until gnt0 is seen.
REQ-006 addr0  input  3  target register index for requester 0.
REQ-007 data0  input  WIDTH  write data for requester 0.
REQ-008 req1, addr1, data1  input  1/3/WIDTH  same meaning as above, for requester 1.
REQ-009 gnt0, gnt1  output  1  one-cycle grant pulse to requester 0 or 1.
REQ-010 chosen  output  NREG  one-hot select, one bit per register.
REQ-011 w_en  output  1  register write strobe.
REQ-012 w_data  output  WIDTH  write data broadcast to all registers.
REQ-013 busy  output  1  high while the FSM is in WRITE.
REQ-014 err  output  1  sticky flag for an out-of-range address.

Function
REQ-015 The FSM SHALL have two states: IDLE and WRITE.
REQ-016 In IDLE, when req0 or req1 is high at the clock edge, the FSM SHALL capture the winner's addr and data and go to WRITE.
REQ-017 In WRITE, the FSM SHALL unconditionally return to IDLE after one cycle; req inputs are not sampled in WRITE.
REQ-018 The maximum throughput SHALL be one write per 2 cycles.
REQ-019 Outputs during WRITE:
- gnt of the winner = 1, the other gnt = 0
- w_en = 1
- chosen = one-hot of the captured address
- w_data = captured data
- busy = 1
REQ-020 Outputs during IDLE: gnt0, gnt1, w_en, chosen and busy SHALL all be 0; w_data SHALL hold its last value.
REQ-021 Latency SHALL be exactly 1 cycle: a req sampled at edge N produces gnt, w_en and chosen in the cycle following edge N.
REQ-022 Round-robin rule: a 1-bit pointer `last` records the requester most recently granted.
REQ-023 When both requests are high, the requester not equal to `last` SHALL win.
REQ-024 When only one request is high, that requester SHALL win and `last` SHALL update to it.
REQ-025 Requester protocol: a requester SHALL drop req in the cycle it sees its gnt (or re-assert it for a new write). A req still high at the next IDLE edge is treated as a new request.
REQ-026 Address handling: when the captured address is >= NREG:
- the grant is still issued
- w_en = 0 and chosen = 0 for that WRITE cycle
- err is set to 1
REQ-027 err SHALL stay at 1 until reset.
REQ-028 Address and data SHALL be captured only at the IDLE->WRITE edge; input changes during WRITE have no effect.
REQ-029 gnt0 and gnt1 SHALL never both be high; chosen SHALL never have more than one bit set.
REQ-030 Neither request may be granted twice without an intervening IDLE cycle.

Reset
REQ-031 While rst is high, asynchronously and independent of clk:
- state = IDLE
- last = 1, so requester 0 wins the first contention
- gnt0 = gnt1 = w_en = busy = err = 0
- chosen = 0
- w_data = 0
REQ-032 Reset asserted during WRITE SHALL abort the write immediately, with w_en falling without waiting for a clock edge. No grant is re-issued after reset release unless req is sampled high again.
REQ-033 The first edge after reset release SHALL behave as a normal IDLE edge.

Verification
REQ-034 Single request: req0=1, addr0=2, data0=10'h155 at edge N -> in the next cycle gnt0=1, w_en=1, chosen=6'b000100, w_data=10'h155; back to IDLE one cycle later.
REQ-035 Contention after reset: req0=req1=1 held continuously -> grant order 0,1,0,1, with gnt pulses every second cycle.
REQ-036 Out-of-range address: req1=1, addr1=7 -> gnt1=1, w_en=0, chosen=0, err=1 from that cycle, and err still 1 after 10 idle cycles.
REQ-037 Input change during WRITE: data0 changes from 10'h3FF to 10'h000 in the WRITE cycle -> w_data stays 10'h3FF.
REQ-038 Reset mid-write: rst pulsed high in the WRITE cycle -> w_en, gnt and chosen drop to 0 at once; err=0; after release, req1 and req0 both high -> requester 0 is granted first.
REQ-039 Checkers on all tests:
- gnt0 & gnt1 never both high
- chosen is one-hot or zero
- w_en implies chosen != 0
- no two consecutive WRITE cycles
